// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO family.
// Latency: none (compile-time only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_DATA_WIDTH = 4;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer addresses 0..depth-1; keep at least one bit for depth 1.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ctr.sv
// Wrapping pointer register: counts 0..MAX-1 and returns to 0 explicitly.
// Latency: advances one cycle after an enabled edge.
// Backpressure: none; caller gates en with its own accept condition.
module fifo_wrap_ctr
  import fifo_pkg::*;
#(
  parameter int MAX = DEFAULT_DEPTH
)(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      en,
  output logic [ptr_width(MAX)-1:0] ptr
);

  localparam int            W    = ptr_width(MAX);
  localparam logic [W-1:0]  LAST = W'(MAX - 1);

  // Explicit wrap so non-power-of-two depths never touch unused addresses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (clr_i) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Parametrised synchronous FIFO with occupancy, almost flags, sticky errors, flush.
// Latency: write-to-read one cycle; data_o registered (one cycle) unless SYNC_FIFO_FWFT_EN.
// Backpressure: writes dropped while full, reads dropped while empty; both flagged sticky.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
)(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        wr_en_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        rd_en_i,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        almost_full_o,
  output logic                        almost_empty_o,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic                        overflow_o,
  output logic                        underflow_o
);

  localparam int            CW       = cnt_width(DEPTH);
  localparam int            PW       = ptr_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || AF_LEVEL > DEPTH) begin : g_param_check
    $error("sync_fifo: DEPTH must be >= 2 and AF_LEVEL must not exceed DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         count_q;
  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         r_ptr;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_q;
  logic                  unf_q;

  // All status is decoded from the registered count, never from pointers.
  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  // Flush wins over any request issued in the same cycle.
  assign wr_acc = wr_en_i && !full  && !clr_i;
  assign rd_acc = rd_en_i && !empty && !clr_i;

  fifo_wrap_ctr #(.MAX(DEPTH)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .en    (wr_acc),
    .ptr   (w_ptr)
  );

  fifo_wrap_ctr #(.MAX(DEPTH)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .en    (rd_acc),
    .ptr   (r_ptr)
  );

  // Storage array; contents deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[w_ptr] <= data_i;
    end
  end

  // Occupancy: net change only when exactly one side is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (wr_acc && !rd_acc) begin
      count_q <= count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_q <= count_q - CW'(1);
    end
  end

  // Sticky error capture; only reset or flush clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clr_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en_i && full) begin
        ovf_q <= 1'b1;
      end
      if (rd_en_i && empty) begin
        unf_q <= 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; zero while nothing is stored.
  assign data_o = empty ? '0 : mem[r_ptr];
`else
  logic [DATA_WIDTH-1:0] data_q;

  // Read register loads only on an accepted pop and holds otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (rd_acc) begin
      data_q <= mem[r_ptr];
    end
  end

  assign data_o = data_q;
`endif

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty_o = (int'(count_q) <= AE_LEVEL);
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one DEPTH=8 and one DEPTH=5 instance share stimulus.
// A queue-based reference model predicts status; a separate monitor pops the
// expected read data whenever a DUT pops a word.
module tb_sync_fifo;

  localparam int DEP8 = 8;
  localparam int DEP5 = 5;
  localparam int AF8  = DEP8 - 2;
  localparam int AF5  = DEP5 - 2;
  localparam int AE   = 2;

  logic       clk_i;
  logic       rst_i;
  logic       clr_i;
  logic       wr_en_i;
  logic       rd_en_i;
  logic [3:0] data_i;

  logic [3:0] d8_data;
  logic       d8_full, d8_empty, d8_af, d8_ae, d8_ovf, d8_unf;
  logic [3:0] d8_count;
  logic [3:0] d5_data;
  logic       d5_full, d5_empty, d5_af, d5_ae, d5_ovf, d5_unf;
  logic [2:0] d5_count;

  sync_fifo #(.DEPTH(DEP8), .DATA_WIDTH(4)) u_dut8 (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (clr_i),
    .wr_en_i (wr_en_i), .data_i (data_i), .rd_en_i (rd_en_i),
    .data_o (d8_data), .full_o (d8_full), .empty_o (d8_empty),
    .almost_full_o (d8_af), .almost_empty_o (d8_ae), .count_o (d8_count),
    .overflow_o (d8_ovf), .underflow_o (d8_unf)
  );

  sync_fifo #(.DEPTH(DEP5), .DATA_WIDTH(4)) u_dut5 (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (clr_i),
    .wr_en_i (wr_en_i), .data_i (data_i), .rd_en_i (rd_en_i),
    .data_o (d5_data), .full_o (d5_full), .empty_o (d5_empty),
    .almost_full_o (d5_af), .almost_empty_o (d5_ae), .count_o (d5_count),
    .overflow_o (d5_ovf), .underflow_o (d5_unf)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: stored contents per instance, sticky flags, and the
  // scoreboard of words each instance is expected to deliver next.
  logic [3:0] mq8[$];
  logic [3:0] mq5[$];
  logic [3:0] exp8[$];
  logic [3:0] exp5[$];
  bit         movf[2];
  bit         munf[2];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle's requests to the model of instance i.
  task automatic step_model(input int i);
    int         n;
    int         dep;
    logic [3:0] v;
    n   = (i == 0) ? mq8.size() : mq5.size();
    dep = (i == 0) ? DEP8 : DEP5;
    if (clr_i) begin
      if (i == 0) mq8.delete(); else mq5.delete();
      movf[i] = 1'b0;
      munf[i] = 1'b0;
      return;
    end
    if (wr_en_i && n == dep) movf[i] = 1'b1;
    if (rd_en_i && n == 0)   munf[i] = 1'b1;
    if (rd_en_i && n > 0) begin
      if (i == 0) begin v = mq8.pop_front(); exp8.push_back(v); end
      else        begin v = mq5.pop_front(); exp5.push_back(v); end
    end
    if (wr_en_i && n < dep) begin
      if (i == 0) mq8.push_back(data_i); else mq5.push_back(data_i);
    end
  endtask

  task automatic reset_model();
    mq8.delete();
    mq5.delete();
    movf[0] = 1'b0; movf[1] = 1'b0;
    munf[0] = 1'b0; munf[1] = 1'b0;
  endtask

  task automatic check_inst(input int i, input int cnt, input int f, input int e,
                            input int af, input int ae, input int ov, input int un);
    int    n;
    int    dep;
    int    afl;
    string t;
    n   = (i == 0) ? mq8.size() : mq5.size();
    dep = (i == 0) ? DEP8 : DEP5;
    afl = (i == 0) ? AF8 : AF5;
    t   = (i == 0) ? "d8" : "d5";
    chk({t, ".count"},        cnt, n);
    chk({t, ".full"},         f,   int'(n == dep));
    chk({t, ".empty"},        e,   int'(n == 0));
    chk({t, ".almost_full"},  af,  int'(n >= afl));
    chk({t, ".almost_empty"}, ae,  int'(n <= AE));
    chk({t, ".overflow"},     ov,  int'(movf[i]));
    chk({t, ".underflow"},    un,  int'(munf[i]));
  endtask

  task automatic check_all();
    check_inst(0, int'(d8_count), int'(d8_full), int'(d8_empty), int'(d8_af),
               int'(d8_ae), int'(d8_ovf), int'(d8_unf));
    check_inst(1, int'(d5_count), int'(d5_full), int'(d5_empty), int'(d5_af),
               int'(d5_ae), int'(d5_ovf), int'(d5_unf));
  endtask

  // One clock cycle of stimulus; entered and left at a falling edge.
  task automatic cyc(input bit w, input bit r, input logic [3:0] d, input bit c);
    wr_en_i = w;
    rd_en_i = r;
    data_i  = d;
    clr_i   = c;
    step_model(0);
    step_model(1);
    @(posedge clk_i);
    @(negedge clk_i);
    check_all();
    if (c) begin
      chk("d8.data_after_clr", int'(d8_data), 0);
      chk("d5.data_after_clr", int'(d5_data), 0);
    end
  endtask

  task automatic mon_cmp(input int i, input logic [3:0] act);
    logic [3:0] e;
    if (i == 0) begin
      if (exp8.size() == 0) begin
        chk("d8.pop_without_expected_word", 1, 0);
        return;
      end
      e = exp8.pop_front();
      chk("d8.read_data", int'(act), int'(e));
    end else begin
      if (exp5.size() == 0) begin
        chk("d5.pop_without_expected_word", 1, 0);
        return;
      end
      e = exp5.pop_front();
      chk("d5.read_data", int'(act), int'(e));
    end
  endtask

  // Monitor: detects each DUT pop and compares the delivered word.
  initial begin
    bit t8;
    bit t5;
    forever begin
      @(negedge clk_i);
      #3;
      t8 = rd_en_i && !d8_empty && !clr_i && !rst_i;
      t5 = rd_en_i && !d5_empty && !clr_i && !rst_i;
`ifdef SYNC_FIFO_FWFT_EN
      if (t8) mon_cmp(0, d8_data);
      if (t5) mon_cmp(1, d5_data);
`else
      @(posedge clk_i);
      #1;
      if (t8) mon_cmp(0, d8_data);
      if (t5) mon_cmp(1, d5_data);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] d;
    rst_i   = 1'b1;
    clr_i   = 1'b0;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    data_i  = '0;
    reset_model();
    repeat (2) @(negedge clk_i);

    // Reset state.
    check_all();
    chk("d8.data_reset", int'(d8_data), 0);
    chk("d5.data_reset", int'(d5_data), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Fill with 1..8: the 8-deep instance uses every entry, the 5-deep one overflows.
    for (int k = 1; k <= 8; k++) cyc(1'b1, 1'b0, 4'(k), 1'b0);
    chk("d8.full_after_fill", int'(d8_full), 1);

    // Drain in order, then one extra read to raise underflow.
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    chk("d8.underflow_persists", int'(d8_unf), 1);

    // Flush with a concurrent write: the write must be dropped.
    cyc(1'b1, 1'b0, 4'hA, 1'b1);

    // Wrap-around: write 3, read 3, write 5, read 5.
    d = 4'h3;
    for (int k = 0; k < 3; k++) begin cyc(1'b1, 1'b0, d, 1'b0); d = d + 4'h1; end
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 4'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin cyc(1'b1, 1'b0, d, 1'b0); d = d + 4'h1; end
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 4'h0, 1'b0);

    // Simultaneous read+write at count 3 holds occupancy.
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b0);

    // Top up to full, then read+write while full: only the read is taken.
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
    cyc(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b0);
    chk("d8.count_full_rdwr", int'(d8_count), DEP8 - 1);

    // Drain, then read+write while empty: only the write is taken.
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b1);

    // Randomized traffic: write-heavy, then read-heavy, rare flushes.
    for (int k = 0; k < 600; k++) begin
      int wp;
      wp = (k < 300) ? 65 : 35;
      cyc(bit'($urandom_range(0, 99) < wp),
          bit'($urandom_range(0, 99) < (100 - wp)),
          4'($urandom_range(0, 15)),
          bit'($urandom_range(0, 79) == 0));
    end

    // Asynchronous reset between edges at count 4.
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
    chk("d8.count_before_arst", int'(d8_count), 4);
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    clr_i   = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    reset_model();
    check_all();
    chk("d8.data_async_reset", int'(d8_data), 0);
    chk("d5.data_async_reset", int'(d5_data), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0);

    chk("d8.words_never_delivered", exp8.size(), 0);
    chk("d5.words_never_delivered", exp5.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
